run_length_histogram: RTL and testbench

- Measures run lengths of identical consecutive bits on a serial `data_in` stream, framed into fixed `FRAME_BITS`-bit frames.
- Keeps two histograms of `MAX_RUN` bins each: one for runs of 0s, one for runs of 1s.
- Supports `data_valid` gaps, splits over-long runs, saturates counts, and reads bins through a registered port with same-edge bypass.
- Sits after the bitstream deserializer as a line-quality monitor; firmware reads it after `frame_done`.

---
 rtl/run_length_histogram_if.sv | 26 ++
 rtl/run_length_histogram.sv | 125 ++++++++++++
 tb/tb_run_length_histogram.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_length_histogram_if.sv
// rtl/run_length_histogram_if.sv - serial sample input and histogram readout bundle
interface run_length_histogram_if #(
    parameter int MAX_RUN = 16,
    parameter int COUNT_W = 11
);
    localparam int AW = $clog2(MAX_RUN);

    logic               data_valid;
    logic               data_in;
    logic               hist_init;
    logic               hist_rd_sel;
    logic [AW-1:0]      hist_addr;
    logic [COUNT_W-1:0] hist_data;
    logic               frame_done;
    logic               sat_flag;

    modport master (
        output data_valid, data_in, hist_init, hist_rd_sel, hist_addr,
        input  hist_data, frame_done, sat_flag
    );

    modport slave (
        input  data_valid, data_in, hist_init, hist_rd_sel, hist_addr,
        output hist_data, frame_done, sat_flag
    );
endinterface

// File: rtl/run_length_histogram.sv
// rtl/run_length_histogram.sv - framed run-length histogram of 0-runs and 1-runs
module run_length_histogram #(
    parameter int FRAME_BITS = 1024,
    parameter int MAX_RUN    = 16,
    parameter int COUNT_W    = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    run_length_histogram_if.slave bus
);
    localparam int AW = $clog2(MAX_RUN);
    localparam int RW = AW + 1;
    localparam int CW = $clog2(FRAME_BITS);
    localparam logic [RW-1:0]      MAX_LEN  = RW'(MAX_RUN);
    localparam logic [CW-1:0]      LAST_BIT = CW'(FRAME_BITS - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = '1;

    logic [COUNT_W-1:0] r_hist [2][MAX_RUN];
    logic [RW-1:0]      r_run_len;
    logic [CW-1:0]      r_bit_cnt;
    logic               r_prev;
    logic               r_frame_done;
    logic               r_sat;
    logic [COUNT_W-1:0] r_hist_data;

    logic               w_c0_en, w_c0_pol;
    logic [AW-1:0]      w_c0_bin;
    logic               w_c1_en, w_c1_pol;
    logic [AW-1:0]      w_c1_bin;
    logic [RW-1:0]      w_run_nxt;
    logic               w_prev_nxt;
    logic               w_last;
    logic               w_sat_hit;
    logic [COUNT_W-1:0] w_hist_nxt [2][MAX_RUN];
    logic [COUNT_W-1:0] w_rd;

    // Commit 0 closes the run by the normal rule; commit 1 flushes the open run at frame end.
    always_comb begin
        w_c0_en    = 1'b0;
        w_c0_pol   = r_prev;
        w_c0_bin   = AW'(r_run_len - RW'(1));
        w_run_nxt  = r_run_len;
        w_prev_nxt = r_prev;
        w_last     = bus.data_valid && (r_bit_cnt == LAST_BIT);
        if (bus.data_valid) begin
            if (r_bit_cnt == '0) begin
                w_run_nxt  = RW'(1);
                w_prev_nxt = bus.data_in;
            end else if (bus.data_in == r_prev) begin
                if (r_run_len == MAX_LEN) begin
                    w_c0_en   = 1'b1;
                    w_run_nxt = RW'(1);
                end else begin
                    w_run_nxt = r_run_len + RW'(1);
                end
            end else begin
                w_c0_en    = 1'b1;
                w_run_nxt  = RW'(1);
                w_prev_nxt = bus.data_in;
            end
        end
        w_c1_en  = w_last;
        w_c1_pol = w_prev_nxt;
        w_c1_bin = AW'(w_run_nxt - RW'(1));
    end

    // The two commits never target the same bin, so each bin sees at most +1 per edge.
    always_comb begin
        w_sat_hit = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < MAX_RUN; k++) begin
                w_hist_nxt[p][k] = r_hist[p][k];
                if ((w_c0_en && w_c0_pol == 1'(p) && w_c0_bin == AW'(k)) ||
                    (w_c1_en && w_c1_pol == 1'(p) && w_c1_bin == AW'(k))) begin
                    if (r_hist[p][k] != CNT_MAX) begin
                        w_hist_nxt[p][k] = r_hist[p][k] + COUNT_W'(1);
                    end
                    if (r_hist[p][k] >= CNT_MAX - COUNT_W'(1)) begin
                        w_sat_hit = 1'b1;
                    end
                end
            end
        end
        w_rd = '0;
        if ({1'b0, bus.hist_addr} < MAX_LEN) begin
            w_rd = w_hist_nxt[bus.hist_rd_sel][bus.hist_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist       <= '{default: '0};
            r_run_len    <= '0;
            r_bit_cnt    <= '0;
            r_prev       <= 1'b0;
            r_frame_done <= 1'b0;
            r_sat        <= 1'b0;
            r_hist_data  <= '0;
        end else if (bus.hist_init) begin
            r_hist       <= '{default: '0};
            r_run_len    <= '0;
            r_bit_cnt    <= '0;
            r_prev       <= 1'b0;
            r_frame_done <= 1'b0;
            r_sat        <= 1'b0;
            r_hist_data  <= '0;
        end else begin
            r_hist       <= w_hist_nxt;
            r_hist_data  <= w_rd;
            r_frame_done <= w_last;
            if (w_sat_hit) begin
                r_sat <= 1'b1;
            end
            if (bus.data_valid) begin
                r_prev    <= w_prev_nxt;
                r_run_len <= w_last ? '0 : w_run_nxt;
                r_bit_cnt <= w_last ? '0 : r_bit_cnt + CW'(1);
            end
        end
    end

    assign bus.hist_data  = r_hist_data;
    assign bus.frame_done = r_frame_done;
    assign bus.sat_flag   = r_sat;
endmodule

// File: tb/tb_run_length_histogram.sv
// tb/tb_run_length_histogram.sv - bench for run_length_histogram across three configurations
module tb_run_length_histogram;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // instance 0: defaults, 1: FRAME_BITS=16 MAX_RUN=4 COUNT_W=4, 2: FRAME_BITS=16 MAX_RUN=12
    logic       v_valid  [3] = '{1'b0, 1'b0, 1'b0};
    logic       v_bit    [3] = '{1'b0, 1'b0, 1'b0};
    logic       v_init   [3] = '{1'b0, 1'b0, 1'b0};
    logic       v_rd_sel [3] = '{1'b0, 1'b0, 1'b0};
    logic [3:0] v_addr   [3] = '{4'd0, 4'd0, 4'd0};
    logic [31:0] o_data  [3];
    logic        o_fd    [3];
    logic        o_sat   [3];

    run_length_histogram_if #(.MAX_RUN(16), .COUNT_W(11)) if_a ();
    run_length_histogram_if #(.MAX_RUN(4),  .COUNT_W(4))  if_b ();
    run_length_histogram_if #(.MAX_RUN(12), .COUNT_W(11)) if_c ();

    run_length_histogram #(.FRAME_BITS(1024), .MAX_RUN(16), .COUNT_W(11)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    run_length_histogram #(.FRAME_BITS(16),   .MAX_RUN(4),  .COUNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(if_b));
    run_length_histogram #(.FRAME_BITS(16),   .MAX_RUN(12), .COUNT_W(11)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    assign if_a.data_valid = v_valid[0];  assign if_a.data_in = v_bit[0];
    assign if_a.hist_init = v_init[0];    assign if_a.hist_rd_sel = v_rd_sel[0];
    assign if_a.hist_addr = v_addr[0];
    assign if_b.data_valid = v_valid[1];  assign if_b.data_in = v_bit[1];
    assign if_b.hist_init = v_init[1];    assign if_b.hist_rd_sel = v_rd_sel[1];
    assign if_b.hist_addr = v_addr[1][1:0];
    assign if_c.data_valid = v_valid[2];  assign if_c.data_in = v_bit[2];
    assign if_c.hist_init = v_init[2];    assign if_c.hist_rd_sel = v_rd_sel[2];
    assign if_c.hist_addr = v_addr[2];

    assign o_data[0] = 32'(if_a.hist_data);  assign o_fd[0] = if_a.frame_done;  assign o_sat[0] = if_a.sat_flag;
    assign o_data[1] = 32'(if_b.hist_data);  assign o_fd[1] = if_b.frame_done;  assign o_sat[1] = if_b.sat_flag;
    assign o_data[2] = 32'(if_c.hist_data);  assign o_fd[2] = if_c.frame_done;  assign o_sat[2] = if_c.sat_flag;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: runs are tracked as unbounded lengths; a run of length N lands as
    // full MAX_RUN chunks (each recorded when the bit after the chunk arrives)
    // plus a final chunk of ((N-1) mod MAX_RUN)+1 when the run closes.
    int F   [3] = '{1024, 16, 16};
    int M   [3] = '{16, 4, 12};
    int LIM [3] = '{2047, 15, 2047};
    int hist [3][2][16];
    int run_pol [3];
    int run_n   [3];
    int nbits   [3];
    int exp_data[3];
    int exp_fd  [3];
    int exp_sat [3];

    task automatic model_clear(input int i);
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 16; k++) hist[i][p][k] = 0;
        run_pol[i] = 0; run_n[i] = 0; nbits[i] = 0;
        exp_data[i] = 0; exp_fd[i] = 0; exp_sat[i] = 0;
    endtask

    task automatic commit(input int i, input int pol, input int len);
        if (hist[i][pol][len-1] < LIM[i]) hist[i][pol][len-1]++;
        if (hist[i][pol][len-1] == LIM[i]) exp_sat[i] = 1;
    endtask

    task automatic model_step(input int i);
        int b;
        if (v_init[i]) begin
            model_clear(i);
            return;
        end
        exp_fd[i] = 0;
        if (v_valid[i]) begin
            b = int'(v_bit[i]);
            if (nbits[i] == 0) begin
                run_pol[i] = b; run_n[i] = 1;
            end else if (b == run_pol[i]) begin
                if (run_n[i] % M[i] == 0) commit(i, b, M[i]);
                run_n[i]++;
            end else begin
                commit(i, run_pol[i], (run_n[i] - 1) % M[i] + 1);
                run_pol[i] = b; run_n[i] = 1;
            end
            nbits[i]++;
            if (nbits[i] == F[i]) begin
                commit(i, run_pol[i], (run_n[i] - 1) % M[i] + 1);
                nbits[i] = 0; run_n[i] = 0; exp_fd[i] = 1;
            end
        end
        exp_data[i] = (int'(v_addr[i]) < M[i]) ? hist[i][int'(v_rd_sel[i])][v_addr[i]] : 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) model_clear(i);
        end else begin
            for (int i = 0; i < 3; i++) model_step(i);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model_data%0d", i), int'(o_data[i]), exp_data[i]);
            check($sformatf("model_fd%0d", i),   int'(o_fd[i]),   exp_fd[i]);
            check($sformatf("model_sat%0d", i),  int'(o_sat[i]),  exp_sat[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic b);
        v_valid[i] = 1'b1;
        v_bit[i]   = b;
        tick();
    endtask

    task automatic do_init(input int i);
        v_valid[i] = 1'b0;
        v_init[i]  = 1'b1;
        tick();
        v_init[i]  = 1'b0;
    endtask

    task automatic rd(input int i, input logic sel, input int addr, output int val);
        v_valid[i]  = 1'b0;
        v_rd_sel[i] = sel;
        v_addr[i]   = 4'(addr);
        tick();
        val = int'(o_data[i]);
    endtask

    task automatic send16(input int i, input logic [15:0] w, input int p1, input int g1,
                          input int p2, input int g2, output int cycles);
        cycles = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == p1) for (int g = 0; g < g1; g++) begin v_valid[i] = 1'b0; tick(); cycles++; end
            if (k == p2) for (int g = 0; g < g2; g++) begin v_valid[i] = 1'b0; tick(); cycles++; end
            send(i, w[15-k]);
            cycles++;
        end
        v_valid[i] = 1'b0;
    endtask

    int val, pulses, cyc;
    logic [15:0] s3;
    int e0 [4] = '{0, 0, 2, 1};
    int e1 [4] = '{0, 1, 0, 1};

    initial begin
        s3 = 16'b0001_1111_1000_0000;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_data%0d", i), int'(o_data[i]), 0);
            check($sformatf("reset_fd%0d", i),   int'(o_fd[i]),   0);
            check($sformatf("reset_sat%0d", i),  int'(o_sat[i]),  0);
        end
        rst = 1'b0;
        tick();

        // Alternating frame starting with 0
        pulses = 0;
        for (int k = 0; k < 1024; k++) begin
            send(0, 1'(k % 2));
            if (k < 1023 && o_fd[0]) pulses++;
        end
        check("t1_fd_after_last", int'(o_fd[0]), 1);
        v_valid[0] = 1'b0;
        tick();
        check("t1_fd_one_cycle", int'(o_fd[0]), 0);
        check("t1_no_early_fd", pulses, 0);
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 16; k++) begin
                rd(0, 1'(p), k, val);
                check($sformatf("t1_bin_%0d_%0d", p, k), val, (k == 0) ? 512 : 0);
            end

        // Bypass: hold zero[0] while a second frame commits into it
        v_rd_sel[0] = 1'b0; v_addr[0] = 4'd0;
        send(0, 1'b0);
        check("t6_hold_512", int'(o_data[0]), 512);
        send(0, 1'b1);
        check("t6_bypass_513", int'(o_data[0]), 513);
        for (int k = 2; k < 1024; k++) send(0, 1'(k % 2));
        check("t6_bypass_1024", int'(o_data[0]), 1024);
        do_init(0);
        check("init_data", int'(o_data[0]), 0);

        // All ones: 64 split runs of 16
        for (int k = 0; k < 1024; k++) send(0, 1'b1);
        v_valid[0] = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 16; k++) begin
                rd(0, 1'(p), k, val);
                check($sformatf("t2_bin_%0d_%0d", p, k), val, (p == 1 && k == 15) ? 64 : 0);
            end
        check("t2_sat", int'(o_sat[0]), 0);

        // Asynchronous reset mid-frame
        rd(0, 1'b1, 15, val);
        check("t6_pre_rst", val, 64);
        for (int k = 0; k < 100; k++) send(0, 1'(k % 2));
        v_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_async_data", int'(o_data[0]), 0);
        check("t6_async_fd",   int'(o_fd[0]),   0);
        check("t6_async_sat",  int'(o_sat[0]),  0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 1024; k++) send(0, 1'(k % 2));
        rd(0, 1'b0, 0, val);  check("t6_fresh_zero0", val, 512);
        rd(0, 1'b1, 0, val);  check("t6_fresh_one0", val, 512);
        rd(0, 1'b1, 15, val); check("t6_fresh_one15", val, 0);

        // Small frame with splits, then same stream with gaps
        do_init(1);
        send16(1, s3, -1, 0, -1, 0, cyc);
        check("t3_cycles", cyc, 16);
        check("t3_fd", int'(o_fd[1]), 1);
        for (int k = 0; k < 4; k++) begin
            rd(1, 1'b0, k, val); check($sformatf("t3_zero%0d", k), val, e0[k]);
            rd(1, 1'b1, k, val); check($sformatf("t3_one%0d", k),  val, e1[k]);
        end
        do_init(1);
        send16(1, s3, 5, 5, 9, 3, cyc);
        check("t4_cycles", cyc, 24);
        check("t4_fd", int'(o_fd[1]), 1);
        for (int k = 0; k < 4; k++) begin
            rd(1, 1'b0, k, val); check($sformatf("t4_zero%0d", k), val, e0[k]);
            rd(1, 1'b1, k, val); check($sformatf("t4_one%0d", k),  val, e1[k]);
        end

        // Saturation over three alternating frames
        do_init(1);
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 16; k++) send(1, 1'(k % 2));
            if (f == 0) check("t5_sat_early", int'(o_sat[1]), 0);
        end
        v_valid[1] = 1'b0;
        rd(1, 1'b0, 0, val); check("t5_zero0_sat", val, 15);
        rd(1, 1'b1, 0, val); check("t5_one0_sat", val, 15);
        check("t5_sat_flag", int'(o_sat[1]), 1);
        do_init(1);
        check("t5_sat_cleared", int'(o_sat[1]), 0);
        rd(1, 1'b0, 0, val); check("t5_zero0_cleared", val, 0);
        rd(1, 1'b1, 0, val); check("t5_one0_cleared", val, 0);

        // Out-of-range read with MAX_RUN=12
        do_init(2);
        send(2, 1'b0); send(2, 1'b0); send(2, 1'b1); send(2, 1'b1); send(2, 1'b1);
        v_valid[2] = 1'b0;
        rd(2, 1'b0, 1, val);  check("oor_valid_bin", val, 1);
        rd(2, 1'b0, 15, val); check("oor_addr15", val, 0);
        rd(2, 1'b1, 12, val); check("oor_addr12", val, 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
